rtc_ctrl: RTL and testbench

Transaction sequencer for the DS1302 three-wire RTC, sitting directly upstream of the RTC serial driver. At boot it optionally programs a start time, then periodically reads seconds, minutes and hours. It drives the driver's Start_Sig, Words_Addr and Write_Data handshake, and publishes a coherent BCD time snapshot to the display logic.

---
 rtl/rtc_pkg.sv | 79 +++++++
 rtl/rtc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_rtc_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and types for the DS1302 transaction sequencer.
package rtc_pkg;

  // DS1302 command bytes
  localparam logic [7:0] SEC_W  = 8'h80;
  localparam logic [7:0] SEC_R  = 8'h81;
  localparam logic [7:0] MIN_W  = 8'h82;
  localparam logic [7:0] MIN_R  = 8'h83;
  localparam logic [7:0] HOUR_W = 8'h84;
  localparam logic [7:0] HOUR_R = 8'h85;
  localparam logic [7:0] CTRL_W = 8'h8E;

  // Control register values (write protect)
  localparam logic [7:0] WP_ON  = 8'h80;
  localparam logic [7:0] WP_OFF = 8'h00;

  // Serial driver start encodings
  localparam logic [1:0] START_IDLE = 2'b00;
  localparam logic [1:0] START_WR   = 2'b10;
  localparam logic [1:0] START_RD   = 2'b01;

  // Last step index of each sequence
  localparam logic [2:0] SET_LAST_STEP  = 3'd4;
  localparam logic [2:0] POLL_LAST_STEP = 3'd2;

  typedef enum logic [1:0] {
    MS_BOOT,
    MS_SET,
    MS_POLL,
    MS_WAIT
  } main_state_t;

  // PH_ISSUE is the resting phase while no transaction is outstanding; the
  // issue itself happens on the edge that loads the driver outputs.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT_DONE,
    PH_GAP
  } phase_t;

  typedef struct packed {
    logic [1:0] start;
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  // Address/data/start for a given sequence step
  function automatic xfer_t step_xfer(input main_state_t seq,
                                      input logic [2:0]  step,
                                      input logic [7:0]  s,
                                      input logic [7:0]  m,
                                      input logic [7:0]  h);
    xfer_t x;
    x = '0;
    case (seq)
      MS_SET: begin
        x.start = START_WR;
        case (step)
          3'd0:    begin x.addr = CTRL_W; x.data = WP_OFF;      end
          3'd1:    begin x.addr = SEC_W;  x.data = s & 8'h7F;   end
          3'd2:    begin x.addr = MIN_W;  x.data = m & 8'h7F;   end
          3'd3:    begin x.addr = HOUR_W; x.data = h & 8'h3F;   end
          default: begin x.addr = CTRL_W; x.data = WP_ON;       end
        endcase
      end
      MS_POLL: begin
        x.start = START_RD;
        case (step)
          3'd0:    x.addr = SEC_R;
          3'd1:    x.addr = MIN_R;
          default: x.addr = HOUR_R;
        endcase
      end
      default: x = '0;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/rtc_ctrl.sv
// DS1302 transaction sequencer: boot-time set, periodic poll, BCD snapshot.
module rtc_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 200,
  parameter bit          INIT_EN     = 1'b1,
  parameter logic [7:0]  INIT_SEC    = 8'h00,
  parameter logic [7:0]  INIT_MIN    = 8'h00,
  parameter logic [7:0]  INIT_HOUR   = 8'h12
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       set_req,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  output logic [1:0] Start_Sig,
  output logic [7:0] Words_Addr,
  output logic [7:0] Write_Data,
  input  logic [7:0] Read_Data,
  input  logic       Done_Sig,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       time_valid,
  output logic       busy
);

  localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  main_state_t main_q, main_d;
  phase_t      phase_q, phase_d;
  logic [2:0]    step_q, step_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [PW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]    start_q, start_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic [7:0]    wr_sec_q, wr_sec_d, wr_min_q, wr_min_d, wr_hour_q, wr_hour_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_sec_q, pend_sec_d, pend_min_q, pend_min_d, pend_hour_q, pend_hour_d;
  logic [7:0]    sh_sec_q, sh_sec_d, sh_min_q, sh_min_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic          tv_q, tv_d, busy_q, busy_d;

  logic          launch, take_pend;
  main_state_t   launch_seq;
  logic [2:0]    launch_step;
  xfer_t         xfer;

  // Next-state: sequence/phase control, capture, commit and pending request
  always_comb begin
    main_d      = main_q;
    phase_d     = phase_q;
    step_d      = step_q;
    gap_cnt_d   = gap_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    start_d     = start_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_sec_d    = wr_sec_q;
    wr_min_d    = wr_min_q;
    wr_hour_d   = wr_hour_q;
    pend_d      = pend_q;
    pend_sec_d  = pend_sec_q;
    pend_min_d  = pend_min_q;
    pend_hour_d = pend_hour_q;
    sh_sec_d    = sh_sec_q;
    sh_min_d    = sh_min_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    tv_d        = 1'b0;
    launch      = 1'b0;
    take_pend   = 1'b0;
    launch_seq  = MS_POLL;
    launch_step = '0;
    xfer        = '0;

    case (main_q)
      MS_BOOT: begin
        wr_sec_d   = INIT_SEC;
        wr_min_d   = INIT_MIN;
        wr_hour_d  = INIT_HOUR;
        launch     = 1'b1;
        launch_seq = INIT_EN ? MS_SET : MS_POLL;
      end
      MS_WAIT: begin
        if (pend_q) begin
          take_pend  = 1'b1;
          launch     = 1'b1;
          launch_seq = MS_SET;
        end else if (wait_cnt_q == POLL_LAST) begin
          launch     = 1'b1;
          launch_seq = MS_POLL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        case (phase_q)
          PH_WAIT_DONE: begin
            if (Done_Sig) begin
              start_d   = START_IDLE;
              phase_d   = PH_GAP;
              gap_cnt_d = '0;
              if (main_q == MS_POLL) begin
                case (step_q)
                  3'd0:    sh_sec_d = Read_Data & 8'h7F;
                  3'd1:    sh_min_d = Read_Data & 8'h7F;
                  default: begin
                    sec_d  = sh_sec_q;
                    min_d  = sh_min_q;
                    hour_d = Read_Data & 8'h3F;
                    tv_d   = 1'b1;
                  end
                endcase
              end
            end
          end
          PH_GAP: begin
            if (gap_cnt_q != GAP_LAST) begin
              gap_cnt_d = gap_cnt_q + 1'b1;
            end else if ((main_q == MS_SET  && step_q != SET_LAST_STEP) ||
                         (main_q == MS_POLL && step_q != POLL_LAST_STEP)) begin
              launch      = 1'b1;
              launch_seq  = main_q;
              launch_step = step_q + 3'd1;
            end else if (main_q == MS_SET) begin
              launch     = 1'b1;
              launch_seq = MS_POLL;
            end else if (pend_q) begin
              take_pend  = 1'b1;
              launch     = 1'b1;
              launch_seq = MS_SET;
            end else begin
              main_d     = MS_WAIT;
              phase_d    = PH_ISSUE;
              wait_cnt_d = '0;
            end
          end
          default: ;
        endcase
      end
    endcase

    if (take_pend) begin
      wr_sec_d  = pend_sec_q;
      wr_min_d  = pend_min_q;
      wr_hour_d = pend_hour_q;
      pend_d    = 1'b0;
    end
    // A request arriving on the service edge stays pending with its own values
    if (set_req) begin
      pend_d      = 1'b1;
      pend_sec_d  = set_sec;
      pend_min_d  = set_min;
      pend_hour_d = set_hour;
    end
    if (launch) begin
      xfer    = step_xfer(launch_seq, launch_step, wr_sec_d, wr_min_d, wr_hour_d);
      main_d  = launch_seq;
      step_d  = launch_step;
      phase_d = PH_WAIT_DONE;
      start_d = xfer.start;
      addr_d  = xfer.addr;
      data_d  = xfer.data;
    end
    busy_d = (main_d != MS_WAIT);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      main_q      <= MS_BOOT;
      phase_q     <= PH_ISSUE;
      step_q      <= '0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      start_q     <= START_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wr_sec_q    <= '0;
      wr_min_q    <= '0;
      wr_hour_q   <= '0;
      pend_q      <= 1'b0;
      pend_sec_q  <= '0;
      pend_min_q  <= '0;
      pend_hour_q <= '0;
      sh_sec_q    <= '0;
      sh_min_q    <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      tv_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      main_q      <= main_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      gap_cnt_q   <= gap_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_sec_q    <= wr_sec_d;
      wr_min_q    <= wr_min_d;
      wr_hour_q   <= wr_hour_d;
      pend_q      <= pend_d;
      pend_sec_q  <= pend_sec_d;
      pend_min_q  <= pend_min_d;
      pend_hour_q <= pend_hour_d;
      sh_sec_q    <= sh_sec_d;
      sh_min_q    <= sh_min_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      tv_q        <= tv_d;
      busy_q      <= busy_d;
    end
  end

  assign Start_Sig  = start_q;
  assign Words_Addr = addr_q;
  assign Write_Data = data_q;
  assign sec        = sec_q;
  assign min        = min_q;
  assign hour       = hour_q;
  assign time_valid = tv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Self-checking bench for rtc_ctrl with a fixed-latency serial-driver BFM.
module tb_rtc_ctrl;

  localparam int unsigned POLL   = 2000;
  localparam int unsigned GAP    = 40;
  localparam int unsigned LAT    = 700;
  localparam int          BUDGET = 20000;

  typedef struct packed { logic [1:0] st; logic [7:0] a; logic [7:0] d; } tx_t;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       set_req = 1'b0;
  logic [7:0] set_sec = '0, set_min = '0, set_hour = '0;
  logic [7:0] Read_Data = '0;
  logic       Done_Sig = 1'b0;
  logic [1:0] Start_Sig;
  logic [7:0] Words_Addr, Write_Data, sec, min, hour;
  logic       time_valid, busy;

  always #10 CLK = ~CLK;

  rtc_ctrl #(
    .POLL_CYCLES(POLL), .GAP_CYCLES(GAP), .INIT_EN(1'b1),
    .INIT_SEC(8'h00), .INIT_MIN(8'h00), .INIT_HOUR(8'h12)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .set_req(set_req),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .Start_Sig(Start_Sig), .Words_Addr(Words_Addr), .Write_Data(Write_Data),
    .Read_Data(Read_Data), .Done_Sig(Done_Sig),
    .sec(sec), .min(min), .hour(hour), .time_valid(time_valid), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] bfm_val [3];
  tx_t  txq[$];
  int   gapq[$];
  logic [23:0] tvq[$];
  bit   direct_sw = 1'b0, unstable = 1'b0, tv_long = 1'b0;
  tx_t  exp_q[$];

  // Driver BFM: Done_Sig one cycle, LAT cycles after Start_Sig leaves idle
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        cnt = 0; Done_Sig = 1'b0;
      end else if (Done_Sig) begin
        Done_Sig = 1'b0; cnt = 0;
      end else if (Start_Sig != 2'b00) begin
        cnt++;
        if (cnt == LAT) begin
          Done_Sig = 1'b1;
          case (Words_Addr)
            8'h81:   Read_Data = bfm_val[0];
            8'h83:   Read_Data = bfm_val[1];
            8'h85:   Read_Data = bfm_val[2];
            default: Read_Data = 8'($urandom);
          endcase
        end
      end else cnt = 0;
    end
  end

  // Bus monitor: transaction log, idle-run lengths, stability, snapshots
  initial begin
    int zero_run;
    logic [1:0] prev;
    logic [7:0] cur_a, cur_d;
    logic prev_tv;
    zero_run = -1; prev = 2'b00; cur_a = '0; cur_d = '0; prev_tv = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev = 2'b00; zero_run = -1; prev_tv = 1'b0;
      end else begin
        if (Start_Sig != 2'b00) begin
          if (prev == 2'b00) begin
            txq.push_back('{Start_Sig, Words_Addr, Write_Data});
            gapq.push_back(zero_run);
            cur_a = Words_Addr; cur_d = Write_Data;
          end else begin
            if (Start_Sig != prev) direct_sw = 1'b1;
            if (Words_Addr != cur_a || Write_Data != cur_d) unstable = 1'b1;
          end
          zero_run = 0;
        end else if (zero_run >= 0) zero_run++;
        if (time_valid) begin
          tvq.push_back({sec, min, hour});
          if (prev_tv) tv_long = 1'b1;
        end
        prev_tv = time_valid;
        prev = Start_Sig;
      end
    end
  end

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation still running at cycle 90000, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: what the DS1302 bus should carry for each sequence
  function automatic void model_set(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    exp_q.push_back('{2'b10, 8'h8E, 8'h00});
    exp_q.push_back('{2'b10, 8'h80, s & 8'h7F});
    exp_q.push_back('{2'b10, 8'h82, m & 8'h7F});
    exp_q.push_back('{2'b10, 8'h84, h & 8'h3F});
    exp_q.push_back('{2'b10, 8'h8E, 8'h80});
  endfunction

  function automatic void model_poll();
    exp_q.push_back('{2'b01, 8'h81, 8'h00});
    exp_q.push_back('{2'b01, 8'h83, 8'h00});
    exp_q.push_back('{2'b01, 8'h85, 8'h00});
  endfunction

  task automatic wait_tx(input int n, output bit ok);
    int c;
    c = 0;
    while (txq.size() < n && c < BUDGET) begin @(negedge CLK); #1; c++; end
    ok = (txq.size() >= n);
  endtask

  task automatic pulse_set(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    @(negedge CLK);
    set_sec = s; set_min = m; set_hour = h; set_req = 1'b1;
    @(negedge CLK);
    set_req = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (5) @(negedge CLK);
    #1;
    total++; if (Start_Sig !== 2'b00) begin bad++; $display("FAIL reset_start: got %b want 00", Start_Sig); end
    total++; if ({Words_Addr, Write_Data} !== 16'h0000) begin bad++; $display("FAIL reset_addr_data: got %h/%h want 00/00", Words_Addr, Write_Data); end
    total++; if ({sec, min, hour} !== 24'h0) begin bad++; $display("FAIL reset_time: got %h/%h/%h want 00/00/00", sec, min, hour); end
    total++; if ({time_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_tv_busy: got %b%b want 00", time_valid, busy); end
  endtask

  task automatic test_boot();
    int base; bit ok;
    bfm_val[0] = 8'h85; bfm_val[1] = 8'h59; bfm_val[2] = 8'hD3;
    exp_q.delete(); model_set(8'h00, 8'h00, 8'h12); model_poll();
    base = txq.size();
    #1 RSTn = 1'b1;
    @(negedge CLK); #1;
    total++; if ({Start_Sig, Words_Addr} !== {2'b10, 8'h8E}) begin bad++; $display("FAIL boot_first_issue: got %b/%h want 10/8e", Start_Sig, Words_Addr); end
    wait_tx(base + 8, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL boot_timeout: got %0d tx want 8", txq.size() - base); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (txq[base+i].st !== exp_q[i].st || txq[base+i].a !== exp_q[i].a ||
          (exp_q[i].st == 2'b10 && txq[base+i].d !== exp_q[i].d)) begin
        bad++;
        $display("FAIL boot_seq[%0d]: got %b/%h/%h want %b/%h/%h", i, txq[base+i].st, txq[base+i].a,
                 txq[base+i].d, exp_q[i].st, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_first_poll();
    int c; int n; bit ok; logic [23:0] want;
    want = {bfm_val[0] & 8'h7F, bfm_val[1] & 8'h7F, bfm_val[2] & 8'h3F};
    c = 0;
    while (tvq.size() == 0 && c < BUDGET) begin @(negedge CLK); #1; c++; end
    total++;
    if (tvq.size() == 0) begin bad++; $display("FAIL first_tv_timeout: got no time_valid want one"); end
    else if (tvq[0] !== want) begin bad++; $display("FAIL first_snapshot: got %h want %h", tvq[0], want); end
    repeat (GAP + 10) @(negedge CLK);
    #1;
    total++; if (tvq.size() !== 1) begin bad++; $display("FAIL first_tv_count: got %0d want 1", tvq.size()); end
    total++; if ({sec, min, hour} !== want) begin bad++; $display("FAIL first_hold: got %h%h%h want %h", sec, min, hour, want); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wait_busy: got %b want 0", busy); end
    n = txq.size();
    wait_tx(n + 1, ok);
    total++;
    if (!ok || txq[n].a !== 8'h81 || gapq[n] !== int'(GAP + POLL)) begin
      bad++; $display("FAIL poll_period: got addr %h idle %0d want 81 idle %0d", txq[n].a, gapq[n], GAP + POLL);
    end
  endtask

  task automatic test_random_polls();
    for (int k = 0; k < 2; k++) begin
      int tvn; int c; int n; bit ok; logic [23:0] want;
      bfm_val[0] = 8'($urandom); bfm_val[1] = 8'($urandom); bfm_val[2] = 8'($urandom);
      want = {bfm_val[0] & 8'h7F, bfm_val[1] & 8'h7F, bfm_val[2] & 8'h3F};
      tvn = tvq.size(); c = 0;
      while (tvq.size() == tvn && c < BUDGET) begin @(negedge CLK); #1; c++; end
      total++;
      if (tvq.size() == tvn) begin bad++; $display("FAIL rand_tv_timeout[%0d]: got none want pulse", k); end
      else if (tvq[tvn] !== want || {sec, min, hour} !== want) begin
        bad++; $display("FAIL rand_snapshot[%0d]: got %h out %h%h%h want %h", k, tvq[tvn], sec, min, hour, want);
      end
      n = txq.size();
      wait_tx(n + 1, ok);
      total++;
      if (!ok || txq[n].a !== 8'h81 || gapq[n] !== int'(GAP + POLL)) begin
        bad++; $display("FAIL rand_period[%0d]: got addr %h idle %0d want 81 idle %0d", k, txq[n].a, gapq[n], GAP + POLL);
      end
    end
  endtask

  task automatic test_two_sets_in_poll();
    int base; bit ok;
    base = txq.size() - 1;
    pulse_set(8'h11, 8'h11, 8'h11);
    repeat (300) @(negedge CLK);
    pulse_set(8'h22, 8'h22, 8'h22);
    exp_q.delete(); model_poll(); model_set(8'h22, 8'h22, 8'h22); model_poll();
    wait_tx(base + 12, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL two_set_timeout: got %0d tx want 12", txq.size() - base); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (txq[base+i].st !== exp_q[i].st || txq[base+i].a !== exp_q[i].a ||
            (exp_q[i].st == 2'b10 && txq[base+i].d !== exp_q[i].d)) begin
          bad++;
          $display("FAIL two_set_seq[%0d]: got %b/%h/%h want %b/%h/%h", i, txq[base+i].st, txq[base+i].a,
                   txq[base+i].d, exp_q[i].st, exp_q[i].a, exp_q[i].d);
        end
      end
      total++;
      if (txq[base+11].a !== 8'h81 || gapq[base+11] !== int'(GAP + POLL)) begin
        bad++; $display("FAIL two_set_single: got addr %h idle %0d want 81 idle %0d", txq[base+11].a, gapq[base+11], GAP + POLL);
      end
    end
  endtask

  task automatic test_set_during_wait();
    for (int k = 0; k < 2; k++) begin
      int base; int c; bit ok; logic [7:0] s, m, h;
      if (k == 0) begin s = 8'h30; m = 8'h45; h = 8'h23; end
      else begin s = 8'($urandom); m = 8'($urandom); h = 8'($urandom); end
      c = 0;
      while (busy !== 1'b0 && c < BUDGET) begin @(negedge CLK); #1; c++; end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wait_entry[%0d]: got busy %b want 0", k, busy); end
      repeat (100) @(negedge CLK);
      base = txq.size();
      pulse_set(s, m, h);
      exp_q.delete(); model_set(s, m, h); model_poll();
      wait_tx(base + 8, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL wset_timeout[%0d]: got %0d tx want 8", k, txq.size() - base); end
      else begin
        total++;
        if (gapq[base] < int'(GAP) || gapq[base] >= int'(GAP + POLL)) begin
          bad++; $display("FAIL wset_abort[%0d]: got idle %0d want %0d..%0d", k, gapq[base], GAP, GAP + POLL - 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
          total++;
          if (txq[base+i].st !== exp_q[i].st || txq[base+i].a !== exp_q[i].a ||
              (exp_q[i].st == 2'b10 && txq[base+i].d !== exp_q[i].d)) begin
            bad++;
            $display("FAIL wset_seq[%0d][%0d]: got %b/%h/%h want %b/%h/%h", k, i, txq[base+i].st, txq[base+i].a,
                     txq[base+i].d, exp_q[i].st, exp_q[i].a, exp_q[i].d);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base; int c; bit ok;
    c = 0;
    while (!(Start_Sig === 2'b01 && Words_Addr === 8'h83) && c < BUDGET) begin @(negedge CLK); #1; c++; end
    total++; if (Words_Addr !== 8'h83) begin bad++; $display("FAIL rmid_find83: got %h want 83", Words_Addr); end
    pulse_set(8'($urandom), 8'($urandom), 8'($urandom));
    repeat (100) @(negedge CLK);
    #3 RSTn = 1'b0;
    #1;
    total++; if (Start_Sig !== 2'b00) begin bad++; $display("FAIL rmid_start: got %b want 00", Start_Sig); end
    total++;
    if ({Words_Addr, Write_Data, sec, min, hour, time_valid, busy} !== 42'h0) begin
      bad++; $display("FAIL rmid_outputs: got %h/%h %h%h%h %b%b want all zero", Words_Addr, Write_Data, sec, min, hour, time_valid, busy);
    end
    repeat (3) @(negedge CLK);
    bfm_val[0] = 8'($urandom); bfm_val[1] = 8'($urandom); bfm_val[2] = 8'($urandom);
    exp_q.delete(); model_set(8'h00, 8'h00, 8'h12); model_poll();
    base = txq.size();
    #1 RSTn = 1'b1;
    wait_tx(base + 9, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_timeout: got %0d tx want 9", txq.size() - base); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (txq[base+i].st !== exp_q[i].st || txq[base+i].a !== exp_q[i].a ||
            (exp_q[i].st == 2'b10 && txq[base+i].d !== exp_q[i].d)) begin
          bad++;
          $display("FAIL rmid_seq[%0d]: got %b/%h/%h want %b/%h/%h", i, txq[base+i].st, txq[base+i].a,
                   txq[base+i].d, exp_q[i].st, exp_q[i].a, exp_q[i].d);
        end
      end
      total++;
      if (txq[base+8].a !== 8'h81 || gapq[base+8] !== int'(GAP + POLL)) begin
        bad++; $display("FAIL rmid_pending_cleared: got addr %h idle %0d want 81 idle %0d", txq[base+8].a, gapq[base+8], GAP + POLL);
      end
    end
  endtask

  task automatic test_gaps();
    int viol;
    viol = 0;
    foreach (gapq[i]) if (gapq[i] >= 0 && gapq[i] < int'(GAP)) viol++;
    total++; if (viol !== 0) begin bad++; $display("FAIL gap_min: got %0d short gaps want 0", viol); end
    total++; if (direct_sw !== 1'b0) begin bad++; $display("FAIL no_direct_switch: got %b want 0", direct_sw); end
    total++; if (unstable !== 1'b0) begin bad++; $display("FAIL addr_data_stable: got %b want 0", unstable); end
    total++; if (tv_long !== 1'b0) begin bad++; $display("FAIL tv_single_cycle: got %b want 0", tv_long); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_first_poll();
    test_random_polls();
    test_two_sets_in_poll();
    test_set_during_wait();
    test_reset_mid();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
